target_port: RTL and testbench
==============================

TARGET_PORT -- requirements
Module: target_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address bits received per transaction.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits per transfer in either direction.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have bus_data  inout  1  shared serial line, LSB first; driven only while bus_data_out_valid=1, else high-Z.
REQ-005 SHALL have bus_data_in_valid  in  1  initiator is driving a valid bit on bus_data this cycle.
REQ-006 SHALL have bus_mode  in  1  1=data phase, 0=address phase.
REQ-007 SHALL have bus_init_rw  in  1  1=write, 0=read.
REQ-008 SHALL have bus_init_ready  in  1  initiator ready to accept read data.
REQ-009 SHALL have target_data_in  in  DATA_WIDTH  read data from local slave; target_data_in_valid  in  1  qualifies it.
REQ-010 SHALL have target_ready  in  1  local slave has completed the write; target_split_req  in  1  local slave requests a split.
REQ-011 SHALL have outputs target_addr_out  out  ADDR_WIDTH, target_addr_out_valid  out  1, target_rw  out  1.
REQ-012 SHALL have outputs target_data_out  out  DATA_WIDTH and target_data_out_valid  out  1 (write data to the local slave).
REQ-013 SHALL have outputs bus_data_out_valid  out  1, target_ack  out  1, target_split  out  1.

Function
REQ-014 FSM states SHALL be IDLE, RX_ADDR, RX_DATA, WAIT_WR, WAIT_RD, SPLIT, TX_DATA.
REQ-015 IDLE/RX_ADDR: each cycle with bus_data_in_valid=1 and bus_mode=0 SHALL store bus_data at bit index = bit counter, then increment the counter; IDLE moves to RX_ADDR on the first bit.
REQ-016 On the ADDR_WIDTH-th address bit SHALL register the full address and bus_init_rw, pulse target_addr_out_valid for 1 cycle on the next edge, clear the counter, and enter RX_DATA (write) or WAIT_RD (read).
REQ-017 RX_DATA: SHALL collect DATA_WIDTH bits qualified by bus_data_in_valid=1 and bus_mode=1; on the last bit SHALL update target_data_out and pulse target_data_out_valid for 1 cycle, then enter WAIT_WR.
REQ-018 Bits whose bus_mode does not match the current phase SHALL be ignored and SHALL NOT advance the counter.
REQ-019 WAIT_WR: on target_ready=1 SHALL pulse target_ack for 1 cycle and return to IDLE.
REQ-020 WAIT_RD: target_data_in_valid=1 SHALL latch target_data_in; the FSM enters TX_DATA once bus_init_ready=1, otherwise holds the latched data.
REQ-021 WAIT_RD: target_split_req=1 with target_data_in_valid=0 SHALL pulse target_split for 1 cycle and enter SPLIT; if both are high in the same cycle, data SHALL win and no split is issued.
REQ-022 SPLIT: SHALL latch data on target_data_in_valid, then enter TX_DATA when bus_init_ready=1.
REQ-023 TX_DATA: SHALL drive one registered bit per cycle, LSB first, with bus_data_out_valid=1 for exactly DATA_WIDTH consecutive cycles.
REQ-024 TX_DATA: SHALL pulse target_ack together with the final bit, then return to IDLE.
REQ-025 While in TX_DATA, bus_data_in_valid SHALL be ignored.
REQ-026 target_rw SHALL hold the captured bus_init_rw until the next address completes.
REQ-027 The bit counter SHALL be wide enough for ADDR_WIDTH and SHALL wrap to 0 at the end of every phase; no partial state SHALL carry into the next transaction.

Reset
REQ-028 On rst=1 at a clock edge, state SHALL be IDLE, all counters and shift registers 0, and every output 0; bus_data SHALL be high-Z.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction; no ack, split or valid pulse SHALL follow the reset.

Structure
REQ-030 Package serial_bus_pkg SHALL hold the target state enum, the ADDR_WIDTH/DATA_WIDTH defaults and the bus_mode encodings (MODE_ADDR=0, MODE_DATA=1), shared with init_port.
REQ-031 The serial deserializer (bit-indexed capture plus counter) SHALL be a sub-module named bus_shift_rx, instantiated for the address and data phases.

Verification
REQ-032 Write: address 0xA5C3 sent LSB first (16 bits, mode 0, rw=1), then data 0x3C (mode 1) -> target_addr_out=0xA5C3 with a 1-cycle valid, target_data_out=0x3C with a 1-cycle valid; target_ready -> 1-cycle target_ack.
REQ-033 Read: address 0x0012 with rw=0, target_data_in=0x81, bus_init_ready=1 -> bus_data sequence 1,0,0,0,0,0,0,1 with bus_data_out_valid high for 8 cycles and target_ack on the 8th.
REQ-034 Split: read with target_split_req=1 -> 1-cycle target_split; later data 0x5A and bus_init_ready -> 0x5A serialized, then ack.
REQ-035 Simultaneous target_split_req and target_data_in_valid=0xFF in WAIT_RD -> no target_split; 0xFF is transmitted.
REQ-036 rst pulsed after 9 address bits -> all outputs 0 and bus_data high-Z; a following full address 0x1234 decodes correctly.
REQ-037 Address bits presented with bus_mode=1 interleaved -> ignored; address decodes correctly.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// -----------------------------------------------------------------------------
// serial_bus_pkg
// Shared definitions for the serial bus target (target_port) and its
// initiator counterpart (init_port): default widths, bus_mode encodings and
// the target-side FSM state enum.
// -----------------------------------------------------------------------------
package serial_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  // bus_mode encodings: which phase the bit on bus_data belongs to.
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    WAIT_WR,
    WAIT_RD,
    SPLIT,
    TX_DATA
  } target_state_e;

endpackage

// File: rtl/target_port_if.sv
// -----------------------------------------------------------------------------
// target_port_if
// Control lines of the serial bus between an initiator (master) and a target
// (slave). The shared bus_data line itself is a plain inout on the target.
//   bus_data_in_valid  initiator drives a valid bit on bus_data this cycle
//   bus_mode           1 = data phase, 0 = address phase
//   bus_init_rw        1 = write, 0 = read
//   bus_init_ready     initiator ready to accept read data
//   bus_data_out_valid target is driving bus_data this cycle
// -----------------------------------------------------------------------------
interface target_port_if;

  logic bus_data_in_valid;
  logic bus_mode;
  logic bus_init_rw;
  logic bus_init_ready;
  logic bus_data_out_valid;

  modport master (
    output bus_data_in_valid,
    output bus_mode,
    output bus_init_rw,
    output bus_init_ready,
    input  bus_data_out_valid
  );

  modport slave (
    input  bus_data_in_valid,
    input  bus_mode,
    input  bus_init_rw,
    input  bus_init_ready,
    output bus_data_out_valid
  );

endinterface

// File: rtl/bus_shift_rx.sv
// -----------------------------------------------------------------------------
// bus_shift_rx
// Serial deserializer: each qualified bit is stored at the index given by the
// bit counter, then the counter advances. On the WIDTH-th bit the completed
// word is presented on word_o together with done_o, and the counter and
// capture register return to zero so nothing carries into the next phase.
//   clk, rst     clock, synchronous active-high reset
//   bit_valid_i  capture bit_i this cycle
//   bit_i        serial input bit (LSB first)
//   word_o       capture register with the current bit merged in
//   done_o       this cycle carries the last bit of the word
// -----------------------------------------------------------------------------
module bus_shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = bit_valid_i && (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_o  = shift_q;
    if (bit_valid_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_q == CNT_W'(i)) word_o[i] = bit_i;
      end
      if (done_o) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = word_o;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values. The capture register is reset along with the
  // counter so an aborted word leaves no stale bits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/target_port.sv
// -----------------------------------------------------------------------------
// target_port
// Serial bus target. Receives an LSB-first address (bus_mode=0), then either
// receives write data (bus_mode=1) for the local slave or fetches read data
// from the local slave and serializes it back on bus_data. A read may be split
// by the local slave and completed later.
//   clk, rst                  clock, synchronous active-high reset
//   bus                       bus control lines (slave modport)
//   bus_data                  shared serial line, driven only during TX_DATA
//   target_data_in(_valid)    read data from the local slave
//   target_ready              local slave finished the write
//   target_split_req          local slave asks to split the read
//   target_addr_out(_valid)   received address, 1-cycle valid pulse
//   target_rw                 captured rw, held until the next address
//   target_data_out(_valid)   write data to the local slave, 1-cycle pulse
//   target_ack                write done, or coincident with last read bit
//   target_split              1-cycle split notification
// -----------------------------------------------------------------------------
module target_port
  import serial_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  target_port_if.slave          bus,
  inout  wire                   bus_data,
  input  logic [DATA_WIDTH-1:0] target_data_in,
  input  logic                  target_data_in_valid,
  input  logic                  target_ready,
  input  logic                  target_split_req,
  output logic [ADDR_WIDTH-1:0] target_addr_out,
  output logic                  target_addr_out_valid,
  output logic                  target_rw,
  output logic [DATA_WIDTH-1:0] target_data_out,
  output logic                  target_data_out_valid,
  output logic                  target_ack,
  output logic                  target_split
);

  localparam int TX_CNT_W = $clog2(DATA_WIDTH + 1);

  target_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wdata_vld_q, wdata_vld_d;
  logic                  ack_q, ack_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_have_q, rd_have_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                  tx_vld_q, tx_vld_d;

  // Bits are only accepted in the phase they belong to; mismatched bus_mode
  // bits never reach a deserializer, so they cannot advance its counter.
  logic addr_bit_en, data_bit_en;
  assign addr_bit_en = ((state_q == IDLE) || (state_q == RX_ADDR))
                       && bus.bus_data_in_valid && (bus.bus_mode == MODE_ADDR);
  assign data_bit_en = (state_q == RX_DATA)
                       && bus.bus_data_in_valid && (bus.bus_mode == MODE_DATA);

  logic [ADDR_WIDTH-1:0] addr_word;
  logic                  addr_done;
  logic [DATA_WIDTH-1:0] data_word;
  logic                  data_done;

  bus_shift_rx #(.WIDTH(ADDR_WIDTH)) u_addr_rx (
    .clk         (clk),
    .rst         (rst),
    .bit_valid_i (addr_bit_en),
    .bit_i       (bus_data),
    .word_o      (addr_word),
    .done_o      (addr_done)
  );

  bus_shift_rx #(.WIDTH(DATA_WIDTH)) u_data_rx (
    .clk         (clk),
    .rst         (rst),
    .bit_valid_i (data_bit_en),
    .bit_i       (bus_data),
    .word_o      (data_word),
    .done_o      (data_done)
  );

  // Fresh data from the slave takes priority over the latched copy, so data
  // arriving together with bus_init_ready goes straight out.
  logic                  rd_avail;
  logic [DATA_WIDTH-1:0] rd_src;
  assign rd_avail = target_data_in_valid || rd_have_q;
  assign rd_src   = target_data_in_valid ? target_data_in : rd_data_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    rd_have_d   = rd_have_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_vld_d    = tx_vld_q;
    addr_vld_d  = 1'b0;
    wdata_vld_d = 1'b0;
    ack_d       = 1'b0;
    split_d     = 1'b0;

    case (state_q)
      IDLE, RX_ADDR: begin
        if (addr_done) begin
          addr_d     = addr_word;
          rw_d       = bus.bus_init_rw;
          addr_vld_d = 1'b1;
          state_d    = bus.bus_init_rw ? RX_DATA : WAIT_RD;
        end else if (addr_bit_en) begin
          state_d = RX_ADDR;
        end
      end

      RX_DATA: begin
        if (data_done) begin
          wdata_d     = data_word;
          wdata_vld_d = 1'b1;
          state_d     = WAIT_WR;
        end
      end

      WAIT_WR: begin
        if (target_ready) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WAIT_RD, SPLIT: begin
        if (target_data_in_valid) begin
          rd_data_d = target_data_in;
          rd_have_d = 1'b1;
        end
        if (rd_avail && bus.bus_init_ready) begin
          tx_shift_d = rd_src;
          tx_cnt_d   = '0;
          tx_vld_d   = 1'b1;
          rd_data_d  = '0;
          rd_have_d  = 1'b0;
          state_d    = TX_DATA;
        end else if ((state_q == WAIT_RD) && target_split_req && !rd_avail) begin
          split_d = 1'b1;
          state_d = SPLIT;
        end
      end

      TX_DATA: begin
        tx_shift_d = tx_shift_q >> 1;
        tx_cnt_d   = tx_cnt_q + TX_CNT_W'(1);
        // ack is registered, so raise it one edge early to line up with the
        // final bit on the wire.
        if (tx_cnt_q == TX_CNT_W'(DATA_WIDTH - 2)) ack_d = 1'b1;
        if (tx_cnt_q == TX_CNT_W'(DATA_WIDTH - 1)) begin
          tx_shift_d = '0;
          tx_cnt_d   = '0;
          tx_vld_d   = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_vld_q  <= 1'b0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      wdata_vld_q <= 1'b0;
      ack_q       <= 1'b0;
      split_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_have_q   <= 1'b0;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      tx_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_vld_q  <= addr_vld_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      wdata_vld_q <= wdata_vld_d;
      ack_q       <= ack_d;
      split_q     <= split_d;
      rd_data_q   <= rd_data_d;
      rd_have_q   <= rd_have_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_vld_q    <= tx_vld_d;
    end
  end

  assign target_addr_out        = addr_q;
  assign target_addr_out_valid  = addr_vld_q;
  assign target_rw              = rw_q;
  assign target_data_out        = wdata_q;
  assign target_data_out_valid  = wdata_vld_q;
  assign target_ack             = ack_q;
  assign target_split           = split_q;
  assign bus.bus_data_out_valid = tx_vld_q;
  assign bus_data               = tx_vld_q ? tx_shift_q[0] : 1'bz;

endmodule

// File: tb/tb_target_port.sv
// -----------------------------------------------------------------------------
// tb_target_port
// Self-checking bench for target_port. A table of transactions is driven on
// the bus; the expected output events of each are queued when it is driven
// and a negedge monitor pops and compares them as the DUT produces them.
// Hand-written sequences cover reset at power-up, mid-address and mid-write.
// -----------------------------------------------------------------------------
module tb_target_port;
  import serial_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  target_port_if bus_if ();

  wire  bus_data;
  logic tb_bit;
  logic tb_en;
  assign bus_data = tb_en ? tb_bit : 1'bz;

  logic [DW-1:0] target_data_in;
  logic          target_data_in_valid;
  logic          target_ready;
  logic          target_split_req;
  logic [AW-1:0] target_addr_out;
  logic          target_addr_out_valid;
  logic          target_rw;
  logic [DW-1:0] target_data_out;
  logic          target_data_out_valid;
  logic          target_ack;
  logic          target_split;

  target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus_if),
    .bus_data              (bus_data),
    .target_data_in        (target_data_in),
    .target_data_in_valid  (target_data_in_valid),
    .target_ready          (target_ready),
    .target_split_req      (target_split_req),
    .target_addr_out       (target_addr_out),
    .target_addr_out_valid (target_addr_out_valid),
    .target_rw             (target_rw),
    .target_data_out       (target_data_out),
    .target_data_out_valid (target_data_out_valid),
    .target_ack            (target_ack),
    .target_split          (target_split)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef enum int {EV_ADDR, EV_WDATA, EV_ACK, EV_SPLIT, EV_BIT, EV_LAST_BIT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%s: got 0x%0h expected no event", kind.name(), val);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind_%s", e.kind.name()), kind, e.kind);
      check($sformatf("event_val_%s", e.kind.name()), val, e.val);
    end
  endtask

  // Last read bit and target_ack must share a cycle: that pair is EV_LAST_BIT.
  always @(negedge clk) begin
    if (!rst) begin
      if (target_addr_out_valid) observe(EV_ADDR, {15'b0, target_rw, target_addr_out});
      if (target_data_out_valid) observe(EV_WDATA, 32'(target_data_out));
      if (target_split)          observe(EV_SPLIT, 32'd0);
      if (bus_if.bus_data_out_valid)
        observe(target_ack ? EV_LAST_BIT : EV_BIT, 32'(bus_data));
      else if (target_ack)
        observe(EV_ACK, 32'd0);
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.bus_data_in_valid = 1'b0;
    bus_if.bus_mode          = MODE_ADDR;
    tb_en                    = 1'b0;
    tb_bit                   = 1'b0;
  endtask

  task automatic drive_bit(input logic mode, input logic b);
    bus_if.bus_data_in_valid = 1'b1;
    bus_if.bus_mode          = mode;
    tb_en                    = 1'b1;
    tb_bit                   = b;
    tick();
  endtask

  // noise inserts a wrong-phase bit before some real bits.
  task automatic send_addr(input logic [AW-1:0] a, input logic rw, input bit noise, input int nbits);
    bus_if.bus_init_rw = rw;
    for (int i = 0; i < nbits; i++) begin
      if (noise && (i % 3 == 1)) drive_bit(MODE_DATA, ~a[i]);
      drive_bit(MODE_ADDR, a[i]);
    end
    idle_bus();
  endtask

  task automatic send_data(input logic [DW-1:0] d, input bit noise);
    for (int i = 0; i < DW; i++) begin
      if (noise && (i % 2 == 0)) drive_bit(MODE_ADDR, ~d[i]);
      drive_bit(MODE_DATA, d[i]);
    end
    idle_bus();
  endtask

  task automatic pulse_ready();
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      #2;
      n++;
    end
    check($sformatf("%s_pending_events", name), exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_out"},       32'(target_addr_out), 0);
    check({tag, "_addr_valid"},     32'(target_addr_out_valid), 0);
    check({tag, "_rw"},             32'(target_rw), 0);
    check({tag, "_data_out"},       32'(target_data_out), 0);
    check({tag, "_data_out_valid"}, 32'(target_data_out_valid), 0);
    check({tag, "_bus_out_valid"},  32'(bus_if.bus_data_out_valid), 0);
    check({tag, "_ack"},            32'(target_ack), 0);
    check({tag, "_split"},          32'(target_split), 0);
  endtask

  // -------------------------------------------------------------- vector table
  // rd_mode: 0 data+ready same cycle, 1 data then late ready,
  //          2 split then data, 3 split_req and data in the same cycle.
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            rd_mode;
    bit            noise;
    logic          exp_split;
    logic [DW-1:0] exp_word;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    push(EV_ADDR, {15'b0, v.rw, v.addr});
    if (v.rw) begin
      push(EV_WDATA, 32'(v.exp_word));
      push(EV_ACK, 32'd0);
    end else begin
      if (v.exp_split) push(EV_SPLIT, 32'd0);
      for (int i = 0; i < DW; i++) push((i == DW - 1) ? EV_LAST_BIT : EV_BIT, 32'(v.exp_word[i]));
    end

    send_addr(v.addr, v.rw, v.noise, AW);
    if (v.rw) begin
      send_data(v.data, v.noise);
      repeat (2) tick();
      pulse_ready();
    end else begin
      tick();
      case (v.rd_mode)
        0: begin
          target_data_in = v.data; target_data_in_valid = 1'b1; bus_if.bus_init_ready = 1'b1;
          tick();
          target_data_in_valid = 1'b0;
        end
        1: begin
          target_data_in = v.data; target_data_in_valid = 1'b1;
          tick();
          target_data_in_valid = 1'b0; target_data_in = ~v.data;
          repeat (3) tick();
          bus_if.bus_init_ready = 1'b1;
        end
        2: begin
          target_split_req = 1'b1;
          tick();
          target_split_req = 1'b0;
          repeat (3) tick();
          target_data_in = v.data; target_data_in_valid = 1'b1;
          tick();
          target_data_in_valid = 1'b0; target_data_in = ~v.data;
          tick();
          bus_if.bus_init_ready = 1'b1;
        end
        default: begin
          target_split_req = 1'b1; target_data_in = v.data;
          target_data_in_valid = 1'b1; bus_if.bus_init_ready = 1'b1;
          tick();
          target_split_req = 1'b0; target_data_in_valid = 1'b0;
        end
      endcase
      // Initiator bits offered while the target transmits must be ignored.
      if (v.noise) begin
        bus_if.bus_data_in_valid = 1'b1;
        bus_if.bus_mode          = MODE_ADDR;
        tb_en                    = 1'b0;
      end
    end

    wait_drain(nm, 80);
    bus_if.bus_init_ready = 1'b0;
    idle_bus();
    check({nm, "_rw_hold"},   32'(target_rw), 32'(v.rw));
    check({nm, "_addr_hold"}, 32'(target_addr_out), 32'(v.addr));
    check({nm, "_tx_idle"},   32'(bus_if.bus_data_out_valid), 0);
    if (v.rw) check({nm, "_wdata_hold"}, 32'(target_data_out), 32'(v.exp_word));
  endtask

  // --------------------------------------------------------------------- main
  initial begin
    vecs[0] = '{rw: 1'b1, addr: 16'hA5C3, data: 8'h3C, rd_mode: 0, noise: 1'b0, exp_split: 1'b0, exp_word: 8'h3C};
    vecs[1] = '{rw: 1'b0, addr: 16'h0012, data: 8'h81, rd_mode: 0, noise: 1'b0, exp_split: 1'b0, exp_word: 8'h81};
    vecs[2] = '{rw: 1'b0, addr: 16'hBEEF, data: 8'h5A, rd_mode: 2, noise: 1'b0, exp_split: 1'b1, exp_word: 8'h5A};
    vecs[3] = '{rw: 1'b0, addr: 16'h0F0F, data: 8'hFF, rd_mode: 3, noise: 1'b0, exp_split: 1'b0, exp_word: 8'hFF};
    vecs[4] = '{rw: 1'b1, addr: 16'hFFFF, data: 8'h00, rd_mode: 0, noise: 1'b1, exp_split: 1'b0, exp_word: 8'h00};
    vecs[5] = '{rw: 1'b0, addr: 16'h8001, data: 8'h6E, rd_mode: 1, noise: 1'b1, exp_split: 1'b0, exp_word: 8'h6E};
    vecs[6] = '{rw: 1'b1, addr: 16'h0000, data: 8'hC5, rd_mode: 0, noise: 1'b1, exp_split: 1'b0, exp_word: 8'hC5};

    rst                   = 1'b1;
    idle_bus();
    bus_if.bus_init_rw    = 1'b0;
    bus_if.bus_init_ready = 1'b0;
    target_data_in        = '0;
    target_data_in_valid  = 1'b0;
    target_ready          = 1'b0;
    target_split_req      = 1'b0;

    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset after 9 address bits: transaction aborted, next address clean.
    send_addr(16'hFFFF, 1'b1, 1'b0, 9);
    rst = 1'b1;
    tick();
    check_all_zero("mid_addr_reset");
    rst = 1'b0;
    tick();
    push(EV_ADDR, {15'b0, 1'b1, 16'h1234});
    push(EV_WDATA, 32'h77);
    push(EV_ACK, 32'd0);
    send_addr(16'h1234, 1'b1, 1'b0, AW);
    send_data(8'h77, 1'b0);
    tick();
    pulse_ready();
    wait_drain("after_reset", 40);
    check("after_reset_addr_hold", 32'(target_addr_out), 32'h1234);

    // Reset while waiting for target_ready: no ack may follow.
    push(EV_ADDR, {15'b0, 1'b1, 16'h4321});
    push(EV_WDATA, 32'h99);
    send_addr(16'h4321, 1'b1, 1'b0, AW);
    send_data(8'h99, 1'b0);
    wait_drain("wait_wr", 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_write_reset");
    pulse_ready();
    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
